// File: rtl/jtag_tap_ctrl_pkg.sv
// Shared JTAG definitions: TAP state encoding, reset tms count and the
// 1149.1 next-state function used by the TAP state machine.
`timescale 1ns/1ps
package jtag_tap_ctrl_pkg;

  localparam int STATE_W_P     = 4;
  // Consecutive tms=1 edges that reach Test-Logic-Reset from any state.
  localparam int TLR_TMS_COUNT = 5;

  // The encoding follows the classic 1149.1 example so that the state
  // value is recognisable in waveforms next to other JTAG IP.
  typedef enum logic [STATE_W_P-1:0] {
    EX2_DR   = 4'h0,
    EX1_DR   = 4'h1,
    SH_DR    = 4'h2,
    PAUSE_DR = 4'h3,
    SEL_IR   = 4'h4,
    UPD_DR   = 4'h5,
    CAP_DR   = 4'h6,
    SEL_DR   = 4'h7,
    EX2_IR   = 4'h8,
    EX1_IR   = 4'h9,
    SH_IR    = 4'hA,
    PAUSE_IR = 4'hB,
    RTI      = 4'hC,
    UPD_IR   = 4'hD,
    CAP_IR   = 4'hE,
    TLR      = 4'hF
  } tap_state_e;

  // Next TAP state for the given current state and sampled tms.
  function automatic tap_state_e tap_next_state(tap_state_e cur, logic tms);
    tap_state_e nxt;
    nxt = TLR;
    case (cur)
      TLR:      nxt = tms ? TLR    : RTI;
      RTI:      nxt = tms ? SEL_DR : RTI;
      SEL_DR:   nxt = tms ? SEL_IR : CAP_DR;
      CAP_DR:   nxt = tms ? EX1_DR : SH_DR;
      SH_DR:    nxt = tms ? EX1_DR : SH_DR;
      EX1_DR:   nxt = tms ? UPD_DR : PAUSE_DR;
      PAUSE_DR: nxt = tms ? EX2_DR : PAUSE_DR;
      EX2_DR:   nxt = tms ? UPD_DR : SH_DR;
      UPD_DR:   nxt = tms ? SEL_DR : RTI;
      SEL_IR:   nxt = tms ? TLR    : CAP_IR;
      CAP_IR:   nxt = tms ? EX1_IR : SH_IR;
      SH_IR:    nxt = tms ? EX1_IR : SH_IR;
      EX1_IR:   nxt = tms ? UPD_IR : PAUSE_IR;
      PAUSE_IR: nxt = tms ? EX2_IR : PAUSE_IR;
      EX2_IR:   nxt = tms ? UPD_IR : SH_IR;
      UPD_IR:   nxt = tms ? SEL_DR : RTI;
      default:  nxt = TLR;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/jtag_tap_ctrl_if.sv
// Connection between the TAP state machine and the logic that consumes
// its state: tms in, encoded state and one-hot decodes out.
`timescale 1ns/1ps
interface jtag_tap_ctrl_if;
  import jtag_tap_ctrl_pkg::*;

  logic                 tms;
  logic [STATE_W_P-1:0] state;
  logic                 state_test_logic_reset;
  logic                 state_capture_ir;
  logic                 state_shift_ir;
  logic                 state_update_ir;
  logic                 state_capture_dr;
  logic                 state_shift_dr;
  logic                 state_update_dr;

  // State machine side: consumes tms, produces state and decodes.
  modport master (
    input  tms,
    output state, state_test_logic_reset, state_capture_ir, state_shift_ir,
           state_update_ir, state_capture_dr, state_shift_dr, state_update_dr
  );

  // Consumer side: supplies tms, observes state and decodes.
  modport slave (
    output tms,
    input  state, state_test_logic_reset, state_capture_ir, state_shift_ir,
           state_update_ir, state_capture_dr, state_shift_dr, state_update_dr
  );
endinterface

// File: rtl/jtag_tap_fsm.sv
// 16-state IEEE 1149.1 TAP controller state machine with combinational
// one-hot decodes, so the decodes carry no extra latency.
`timescale 1ns/1ps
module jtag_tap_fsm
  import jtag_tap_ctrl_pkg::*;
(
  input  logic              tck,
  input  logic              trst_n,
  jtag_tap_ctrl_if.master   tap
);

  tap_state_e state_reg;

  // Advance the TAP state on each rising tck; trst_n forces TLR at once.
  always_ff @(posedge tck or negedge trst_n) begin
    if (!trst_n) begin
      state_reg <= TLR;
    end else begin
      state_reg <= tap_next_state(state_reg, tap.tms);
    end
  end

  assign tap.state                  = state_reg;
  assign tap.state_test_logic_reset = (state_reg == TLR);
  assign tap.state_capture_ir       = (state_reg == CAP_IR);
  assign tap.state_shift_ir         = (state_reg == SH_IR);
  assign tap.state_update_ir        = (state_reg == UPD_IR);
  assign tap.state_capture_dr       = (state_reg == CAP_DR);
  assign tap.state_shift_dr         = (state_reg == SH_DR);
  assign tap.state_update_dr        = (state_reg == UPD_DR);

endmodule

// File: rtl/jtag_tap_ctrl.sv
// JTAG TAP controller: state machine, bypass register and the
// falling-edge tdo / tdo_oe output stage.
`timescale 1ns/1ps
module jtag_tap_ctrl
  import jtag_tap_ctrl_pkg::*;
#(
  parameter int STATE_W = STATE_W_P
) (
  input  logic               tck,
  input  logic               trst_n,
  input  logic               tms,
  input  logic               tdi,
  input  logic               insn_tdo,
  input  logic               dr_tdo,
  input  logic               bypass_sel,
  output logic [STATE_W-1:0] state,
  output logic               state_test_logic_reset,
  output logic               state_capture_ir,
  output logic               state_shift_ir,
  output logic               state_update_ir,
  output logic               state_capture_dr,
  output logic               state_shift_dr,
  output logic               state_update_dr,
  output logic               tdo,
  output logic               tdo_oe
);

  jtag_tap_ctrl_if tap_if ();

  logic bypass_reg;
  logic tdo_reg;
  logic tdo_oe_reg;
  logic tdo_next;
  logic tdo_oe_next;

  assign tap_if.tms = tms;

  jtag_tap_fsm u_fsm (
    .tck    (tck),
    .trst_n (trst_n),
    .tap    (tap_if.master)
  );

  assign state                  = tap_if.state;
  assign state_test_logic_reset = tap_if.state_test_logic_reset;
  assign state_capture_ir       = tap_if.state_capture_ir;
  assign state_shift_ir         = tap_if.state_shift_ir;
  assign state_update_ir        = tap_if.state_update_ir;
  assign state_capture_dr       = tap_if.state_capture_dr;
  assign state_shift_dr         = tap_if.state_shift_dr;
  assign state_update_dr        = tap_if.state_update_dr;

  // Bypass register: captures 0 in CAP_DR, shifts tdi in SH_DR, else holds.
  always_ff @(posedge tck or negedge trst_n) begin
    if (!trst_n) begin
      bypass_reg <= 1'b0;
    end else if (bypass_sel) begin
      if (tap_if.state_capture_dr) begin
        bypass_reg <= 1'b0;
      end else if (tap_if.state_shift_dr) begin
        bypass_reg <= tdi;
      end
    end
  end

  // Select the serial source for the current shift state; idle value is 0.
  always_comb begin
    tdo_next    = 1'b0;
    tdo_oe_next = tap_if.state_shift_ir | tap_if.state_shift_dr;
    if (tap_if.state_shift_ir) begin
      tdo_next = insn_tdo;
    end else if (tap_if.state_shift_dr) begin
      tdo_next = bypass_sel ? bypass_reg : dr_tdo;
    end
  end

  // Register tdo and its enable on falling tck so they only move there.
  always_ff @(negedge tck or negedge trst_n) begin
    if (!trst_n) begin
      tdo_reg    <= 1'b0;
      tdo_oe_reg <= 1'b0;
    end else begin
      tdo_reg    <= tdo_next;
      tdo_oe_reg <= tdo_oe_next;
    end
  end

  assign tdo    = tdo_reg;
  assign tdo_oe = tdo_oe_reg;

endmodule
